// File: rtl/imuldiv_div_requester.sv
// imuldiv_div_requester: carries one divide operation from the execute stage
// through the divider's val/rdy request/response interface, then presents the
// selected quotient or remainder with its destination tag to writeback.
// Only one operation is in flight at a time.
// Optional build macro IMULDIV_DIVZERO_BYPASS_EN: when defined, divide-by-zero
// is answered locally (quotient all-ones, remainder = dividend) without a
// divider request; when undefined, it goes to the divider like any other op.
module imuldiv_div_requester #(
  parameter int TAG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             op_val_i,
  output logic             op_rdy_o,
  input  logic             op_fn_i,
  input  logic             op_sel_rem_i,
  input  logic [31:0]      op_a_i,
  input  logic [31:0]      op_b_i,
  input  logic [TAG_W-1:0] op_tag_i,
  output logic             divreq_msg_fn_o,
  output logic [31:0]      divreq_msg_a_o,
  output logic [31:0]      divreq_msg_b_o,
  output logic             divreq_val_o,
  input  logic             divreq_rdy_i,
  input  logic [63:0]      divresp_msg_result_i,
  input  logic             divresp_val_i,
  output logic             divresp_rdy_o,
  output logic             wb_val_o,
  input  logic             wb_rdy_i,
  output logic [31:0]      wb_data_o,
  output logic [TAG_W-1:0] wb_tag_o,
  output logic [CNT_W-1:0] done_count_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    WB   = 2'd3
  } state_e;

  state_e             state_q;
  logic               op_rdy_q;
  logic               divreq_val_q;
  logic               divresp_rdy_q;
  logic               wb_val_q;
  logic               fn_q;
  logic               sel_rem_q;
  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic [TAG_W-1:0]   tag_q;
  logic [31:0]        wb_data_q;
  logic [TAG_W-1:0]   wb_tag_q;
  logic [CNT_W-1:0]   done_count_q;
  logic [CNT_W-1:0]   done_count_d;
  logic [31:0]        resp_sel;

`ifdef IMULDIV_DIVZERO_BYPASS_EN
  logic               div_zero;
  logic [31:0]        bypass_data;

  // Divide-by-zero answer computed straight from the incoming operands
  assign div_zero    = (op_b_i == 32'd0);
  assign bypass_data = op_sel_rem_i ? op_a_i : 32'hFFFF_FFFF;
`endif

  // Pick remainder (upper half) or quotient (lower half) of the divider response
  assign resp_sel = sel_rem_q ? divresp_msg_result_i[63:32] : divresp_msg_result_i[31:0];

  // Completed-op counter sticks at all-ones instead of wrapping
  always_comb begin
    done_count_d = done_count_q;
    if (done_count_q != {CNT_W{1'b1}}) begin
      done_count_d = done_count_q + CNT_W'(1);
    end
  end

  // Control FSM; every handshake output is a register set alongside the state
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= IDLE;
      op_rdy_q      <= 1'b1;
      divreq_val_q  <= 1'b0;
      divresp_rdy_q <= 1'b0;
      wb_val_q      <= 1'b0;
      fn_q          <= 1'b0;
      sel_rem_q     <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      tag_q         <= '0;
      wb_data_q     <= '0;
      wb_tag_q      <= '0;
      done_count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (op_val_i && op_rdy_q) begin
            fn_q      <= op_fn_i;
            sel_rem_q <= op_sel_rem_i;
            a_q       <= op_a_i;
            b_q       <= op_b_i;
            tag_q     <= op_tag_i;
            op_rdy_q  <= 1'b0;
`ifdef IMULDIV_DIVZERO_BYPASS_EN
            if (div_zero) begin
              wb_data_q <= bypass_data;
              wb_tag_q  <= op_tag_i;
              wb_val_q  <= 1'b1;
              state_q   <= WB;
            end else begin
              divreq_val_q <= 1'b1;
              state_q      <= REQ;
            end
`else
            divreq_val_q <= 1'b1;
            state_q      <= REQ;
`endif
          end
        end
        REQ: begin
          if (divreq_rdy_i) begin
            divreq_val_q  <= 1'b0;
            divresp_rdy_q <= 1'b1;
            state_q       <= WAIT;
          end
        end
        WAIT: begin
          if (divresp_val_i) begin
            wb_data_q     <= resp_sel;
            wb_tag_q      <= tag_q;
            divresp_rdy_q <= 1'b0;
            wb_val_q      <= 1'b1;
            state_q       <= WB;
          end
        end
        WB: begin
          if (wb_rdy_i) begin
            done_count_q <= done_count_d;
            wb_val_q     <= 1'b0;
            op_rdy_q     <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          op_rdy_q      <= 1'b1;
          divreq_val_q  <= 1'b0;
          divresp_rdy_q <= 1'b0;
          wb_val_q      <= 1'b0;
          state_q       <= IDLE;
        end
      endcase
    end
  end

  assign op_rdy_o        = op_rdy_q;
  assign divreq_val_o    = divreq_val_q;
  assign divresp_rdy_o   = divresp_rdy_q;
  assign wb_val_o        = wb_val_q;
  assign divreq_msg_fn_o = fn_q;
  assign divreq_msg_a_o  = a_q;
  assign divreq_msg_b_o  = b_q;
  assign wb_data_o       = wb_data_q;
  assign wb_tag_o        = wb_tag_q;
  assign done_count_o    = done_count_q;

endmodule

// File: tb/tb_imuldiv_div_requester.sv
// Testbench for imuldiv_div_requester: directed operations with a hand-driven
// divider stub and writeback sink; inputs change and outputs are sampled on
// the falling clock edge.
module tb_imuldiv_div_requester;

  logic        clk;
  logic        resetN;
  logic        opVal;
  logic        opRdy;
  logic        opFn;
  logic        opSelRem;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [4:0]  opTag;
  logic        reqFn;
  logic [31:0] reqA;
  logic [31:0] reqB;
  logic        reqVal;
  logic        reqRdy;
  logic [63:0] respMsg;
  logic        respVal;
  logic        respRdy;
  logic        wbVal;
  logic        wbRdy;
  logic [31:0] wbData;
  logic [4:0]  wbTag;
  logic [31:0] doneCount;

  int checks;
  int errors;
  int expDone;

  imuldiv_div_requester #(.TAG_W(5), .CNT_W(32)) dut (
    .clk_i                (clk),
    .reset_n_i            (resetN),
    .op_val_i             (opVal),
    .op_rdy_o             (opRdy),
    .op_fn_i              (opFn),
    .op_sel_rem_i         (opSelRem),
    .op_a_i               (opA),
    .op_b_i               (opB),
    .op_tag_i             (opTag),
    .divreq_msg_fn_o      (reqFn),
    .divreq_msg_a_o       (reqA),
    .divreq_msg_b_o       (reqB),
    .divreq_val_o         (reqVal),
    .divreq_rdy_i         (reqRdy),
    .divresp_msg_result_i (respMsg),
    .divresp_val_i        (respVal),
    .divresp_rdy_o        (respRdy),
    .wb_val_o             (wbVal),
    .wb_rdy_i             (wbRdy),
    .wb_data_o            (wbData),
    .wb_tag_o             (wbTag),
    .done_count_o         (doneCount)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drives one op through the full handshake, acting as divider stub and
  // writeback sink; returns what was observed on the interfaces
  task automatic runOp(input logic fn, input logic sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag,
                       input logic [63:0] result,
                       output logic oWb, output logic oReq, output logic oFn,
                       output logic [31:0] oA, output logic [31:0] oB,
                       output logic [31:0] oData, output logic [4:0] oTag,
                       output int oLat);
    int guard;
    oWb = 1'b0; oReq = 1'b0; oFn = 1'b0; oA = '0; oB = '0;
    oData = '0; oTag = '0; oLat = 0;
    opVal = 1'b1; opFn = fn; opSelRem = sel; opA = a; opB = b; opTag = tag;
    guard = 0;
    while (opRdy !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    opVal = 1'b0;
    oLat = 1;
    while (wbVal !== 1'b1 && oLat < 50) begin
      reqRdy = 1'b0;
      respVal = 1'b0;
      if (reqVal === 1'b1) begin
        if (!oReq) begin
          oFn = reqFn;
          oA  = reqA;
          oB  = reqB;
        end
        oReq = 1'b1;
        reqRdy = 1'b1;
      end
      if (respRdy === 1'b1) begin
        respVal = 1'b1;
        respMsg = result;
      end
      @(negedge clk);
      oLat++;
    end
    reqRdy = 1'b0;
    respVal = 1'b0;
    if (wbVal === 1'b1) begin
      oWb = 1'b1;
      oData = wbData;
      oTag = wbTag;
      wbRdy = 1'b1;
      @(negedge clk);
      wbRdy = 1'b0;
      expDone++;
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    #1;
    checks++; if (opRdy !== 1'b1) begin errors++; $display("[TB] FAIL reset_op_rdy: got %b expected 1", opRdy); end
    checks++; if (reqVal !== 1'b0) begin errors++; $display("[TB] FAIL reset_divreq_val: got %b expected 0", reqVal); end
    checks++; if (respRdy !== 1'b0) begin errors++; $display("[TB] FAIL reset_divresp_rdy: got %b expected 0", respRdy); end
    checks++; if (wbVal !== 1'b0) begin errors++; $display("[TB] FAIL reset_wb_val: got %b expected 0", wbVal); end
    checks++; if (wbData !== 32'd0) begin errors++; $display("[TB] FAIL reset_wb_data: got %h expected 0", wbData); end
    checks++; if (wbTag !== 5'd0) begin errors++; $display("[TB] FAIL reset_wb_tag: got %h expected 0", wbTag); end
    checks++; if (doneCount !== 32'd0) begin errors++; $display("[TB] FAIL reset_done_count: got %0d expected 0", doneCount); end
    checks++; if (reqA !== 32'd0 || reqB !== 32'd0 || reqFn !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_msg: got %b/%h/%h expected 0/0/0", reqFn, reqA, reqB); end
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    checks++; if (opRdy !== 1'b1 || reqVal !== 1'b0) begin errors++; $display("[TB] FAIL reset_release: got op_rdy=%b divreq_val=%b expected 1/0", opRdy, reqVal); end
    expDone = 0;
  endtask

  task automatic test_unsigned_quot();
    logic w, r, f; logic [31:0] a, b, d; logic [4:0] t; int lat;
    runOp(1'b0, 1'b0, 32'h075BCD15, 32'h00002710, 5'd3, 64'h00001A85_00003039,
          w, r, f, a, b, d, t, lat);
    checks++; if (w !== 1'b1) begin errors++; $display("[TB] FAIL uq_wb_seen: got %b expected 1", w); end
    checks++; if (r !== 1'b1 || f !== 1'b0 || a !== 32'h075BCD15 || b !== 32'h00002710) begin errors++; $display("[TB] FAIL uq_req_msg: got %b/%b/%h/%h expected 1/0/075bcd15/00002710", r, f, a, b); end
    checks++; if (d !== 32'h00003039) begin errors++; $display("[TB] FAIL uq_wb_data: got %h expected 00003039", d); end
    checks++; if (t !== 5'd3) begin errors++; $display("[TB] FAIL uq_wb_tag: got %0d expected 3", t); end
    checks++; if (lat != 3) begin errors++; $display("[TB] FAIL uq_latency: got %0d expected 3", lat); end
    checks++; if (doneCount !== 32'd1) begin errors++; $display("[TB] FAIL uq_done_count: got %0d expected 1", doneCount); end
    checks++; if (opRdy !== 1'b1 || wbVal !== 1'b0) begin errors++; $display("[TB] FAIL uq_back_idle: got op_rdy=%b wb_val=%b expected 1/0", opRdy, wbVal); end
  endtask

  task automatic test_signed_rem();
    logic w, r, f; logic [31:0] a, b, d; logic [4:0] t; int lat;
    runOp(1'b1, 1'b1, 32'h0A01B044, 32'hFFFFB14A, 5'd17, 64'h00003372_FFFFDF75,
          w, r, f, a, b, d, t, lat);
    checks++; if (r !== 1'b1 || f !== 1'b1 || a !== 32'h0A01B044 || b !== 32'hFFFFB14A) begin errors++; $display("[TB] FAIL sr_req_msg: got %b/%b/%h/%h expected 1/1/0a01b044/ffffb14a", r, f, a, b); end
    checks++; if (w !== 1'b1 || d !== 32'h00003372) begin errors++; $display("[TB] FAIL sr_wb_data: got %b/%h expected 1/00003372", w, d); end
    checks++; if (t !== 5'd17) begin errors++; $display("[TB] FAIL sr_wb_tag: got %0d expected 17", t); end
    checks++; if (doneCount !== expDone) begin errors++; $display("[TB] FAIL sr_done_count: got %0d expected %0d", doneCount, expDone); end
  endtask

  task automatic test_backpressure();
    opVal = 1'b1; opFn = 1'b0; opSelRem = 1'b1; opA = 32'd100; opB = 32'd7; opTag = 5'd9;
    @(negedge clk);
    opVal = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (reqVal !== 1'b1 || reqA !== 32'd100 || reqB !== 32'd7 || reqFn !== 1'b0 || opRdy !== 1'b0) begin errors++; $display("[TB] FAIL bp_req_hold%0d: got val=%b a=%h b=%h fn=%b op_rdy=%b expected 1/64/7/0/0", i, reqVal, reqA, reqB, reqFn, opRdy); end
      @(negedge clk);
    end
    reqRdy = 1'b1;
    @(negedge clk);
    reqRdy = 1'b0;
    checks++; if (respRdy !== 1'b1 || reqVal !== 1'b0) begin errors++; $display("[TB] FAIL bp_wait: got divresp_rdy=%b divreq_val=%b expected 1/0", respRdy, reqVal); end
    respVal = 1'b1; respMsg = {32'd2, 32'd14};
    @(negedge clk);
    respVal = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (wbVal !== 1'b1 || wbData !== 32'd2 || wbTag !== 5'd9 || opRdy !== 1'b0 || doneCount !== expDone) begin errors++; $display("[TB] FAIL bp_wb_hold%0d: got val=%b data=%h tag=%0d op_rdy=%b cnt=%0d expected 1/2/9/0/%0d", i, wbVal, wbData, wbTag, opRdy, doneCount, expDone); end
      @(negedge clk);
    end
    wbRdy = 1'b1;
    @(negedge clk);
    wbRdy = 1'b0;
    expDone++;
    checks++; if (wbVal !== 1'b0 || opRdy !== 1'b1 || doneCount !== expDone) begin errors++; $display("[TB] FAIL bp_release: got wb_val=%b op_rdy=%b cnt=%0d expected 0/1/%0d", wbVal, opRdy, doneCount, expDone); end
    @(negedge clk);
    checks++; if (doneCount !== expDone) begin errors++; $display("[TB] FAIL bp_single_count: got %0d expected %0d", doneCount, expDone); end
  endtask

  task automatic test_back_to_back();
    logic w, r, f; logic [31:0] a, b, d; logic [4:0] t; int lat;
    opVal = 1'b1; opFn = 1'b0; opSelRem = 1'b0; opA = 32'd7; opB = 32'd5; opTag = 5'd1;
    @(negedge clk);
    opA = 32'hFFFFFFFF; opB = 32'd2; opTag = 5'd2;
    checks++; if (reqA !== 32'd7 || reqB !== 32'd5 || opRdy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_first_req: got a=%h b=%h op_rdy=%b expected 7/5/0", reqA, reqB, opRdy); end
    reqRdy = 1'b1;
    @(negedge clk);
    reqRdy = 1'b0;
    checks++; if (opRdy !== 1'b0 || respRdy !== 1'b1 || reqA !== 32'd7) begin errors++; $display("[TB] FAIL b2b_wait: got op_rdy=%b divresp_rdy=%b a=%h expected 0/1/7", opRdy, respRdy, reqA); end
    respVal = 1'b1; respMsg = {32'd2, 32'd1};
    @(negedge clk);
    respVal = 1'b0;
    checks++; if (wbVal !== 1'b1 || wbData !== 32'd1 || wbTag !== 5'd1 || opRdy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_first_wb: got val=%b data=%h tag=%0d op_rdy=%b expected 1/1/1/0", wbVal, wbData, wbTag, opRdy); end
    wbRdy = 1'b1;
    @(negedge clk);
    wbRdy = 1'b0;
    expDone++;
    checks++; if (opRdy !== 1'b1 || reqVal !== 1'b0 || wbVal !== 1'b0) begin errors++; $display("[TB] FAIL b2b_gap: got op_rdy=%b divreq_val=%b wb_val=%b expected 1/0/0", opRdy, reqVal, wbVal); end
    runOp(1'b0, 1'b0, 32'hFFFFFFFF, 32'd2, 5'd2, {32'd1, 32'h7FFFFFFF},
          w, r, f, a, b, d, t, lat);
    checks++; if (r !== 1'b1 || a !== 32'hFFFFFFFF || b !== 32'd2) begin errors++; $display("[TB] FAIL b2b_second_req: got %b/%h/%h expected 1/ffffffff/2", r, a, b); end
    checks++; if (w !== 1'b1 || d !== 32'h7FFFFFFF || t !== 5'd2) begin errors++; $display("[TB] FAIL b2b_second_wb: got %b/%h/%0d expected 1/7fffffff/2", w, d, t); end
    checks++; if (doneCount !== expDone) begin errors++; $display("[TB] FAIL b2b_done_count: got %0d expected %0d", doneCount, expDone); end
  endtask

  task automatic test_reset_mid_op();
    opVal = 1'b1; opFn = 1'b0; opSelRem = 1'b0; opA = 32'h1234; opB = 32'h10; opTag = 5'd6;
    @(negedge clk);
    opVal = 1'b0;
    reqRdy = 1'b1;
    @(negedge clk);
    reqRdy = 1'b0;
    checks++; if (respRdy !== 1'b1) begin errors++; $display("[TB] FAIL rst_in_wait: got divresp_rdy=%b expected 1", respRdy); end
    #2;
    resetN = 1'b0;
    #1;
    checks++; if (opRdy !== 1'b1 || reqVal !== 1'b0 || respRdy !== 1'b0 || wbVal !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_hs: got op_rdy=%b dv=%b dr=%b wv=%b expected 1/0/0/0", opRdy, reqVal, respRdy, wbVal); end
    checks++; if (wbData !== 32'd0 || wbTag !== 5'd0 || doneCount !== 32'd0 || reqA !== 32'd0) begin errors++; $display("[TB] FAIL rst_async_regs: got data=%h tag=%0d cnt=%0d a=%h expected 0/0/0/0", wbData, wbTag, doneCount, reqA); end
    expDone = 0;
    @(negedge clk);
    resetN = 1'b1;
    respVal = 1'b1; respMsg = 64'hDEAD_BEEF_0000_0001;
    @(negedge clk);
    respVal = 1'b0;
    checks++; if (opRdy !== 1'b1 || wbVal !== 1'b0 || respRdy !== 1'b0 || doneCount !== 32'd0) begin errors++; $display("[TB] FAIL rst_after_release: got op_rdy=%b wv=%b dr=%b cnt=%0d expected 1/0/0/0", opRdy, wbVal, respRdy, doneCount); end
  endtask

  task automatic test_divzero();
    logic w, r, f; logic [31:0] a, b, d; logic [4:0] t; int lat;
`ifdef IMULDIV_DIVZERO_BYPASS_EN
    runOp(1'b1, 1'b1, 32'h00000222, 32'd0, 5'd4, 64'd0, w, r, f, a, b, d, t, lat);
    checks++; if (r !== 1'b0) begin errors++; $display("[TB] FAIL dz_no_request: got %b expected 0", r); end
    checks++; if (lat != 1) begin errors++; $display("[TB] FAIL dz_latency: got %0d expected 1", lat); end
    checks++; if (w !== 1'b1 || d !== 32'h00000222 || t !== 5'd4) begin errors++; $display("[TB] FAIL dz_rem: got %b/%h/%0d expected 1/00000222/4", w, d, t); end
    runOp(1'b1, 1'b0, 32'h00000222, 32'd0, 5'd5, 64'd0, w, r, f, a, b, d, t, lat);
    checks++; if (r !== 1'b0 || w !== 1'b1 || d !== 32'hFFFFFFFF || t !== 5'd5) begin errors++; $display("[TB] FAIL dz_quot: got %b/%b/%h/%0d expected 0/1/ffffffff/5", r, w, d, t); end
`else
    runOp(1'b1, 1'b1, 32'h00000222, 32'd0, 5'd4, {32'h00000222, 32'hFFFFFFFF}, w, r, f, a, b, d, t, lat);
    checks++; if (r !== 1'b1 || b !== 32'd0 || a !== 32'h00000222) begin errors++; $display("[TB] FAIL dz_request: got %b/%h/%h expected 1/00000222/0", r, a, b); end
    checks++; if (lat != 3) begin errors++; $display("[TB] FAIL dz_latency: got %0d expected 3", lat); end
    checks++; if (w !== 1'b1 || d !== 32'h00000222 || t !== 5'd4) begin errors++; $display("[TB] FAIL dz_rem: got %b/%h/%0d expected 1/00000222/4", w, d, t); end
    runOp(1'b1, 1'b0, 32'h00000222, 32'd0, 5'd5, {32'h00000222, 32'hFFFFFFFF}, w, r, f, a, b, d, t, lat);
    checks++; if (r !== 1'b1 || w !== 1'b1 || d !== 32'hFFFFFFFF || t !== 5'd5) begin errors++; $display("[TB] FAIL dz_quot: got %b/%b/%h/%0d expected 1/1/ffffffff/5", r, w, d, t); end
`endif
    checks++; if (doneCount !== expDone) begin errors++; $display("[TB] FAIL dz_done_count: got %0d expected %0d", doneCount, expDone); end
  endtask

  // Runs every scenario in order, then prints the summary
  initial begin
    checks = 0; errors = 0; expDone = 0;
    resetN = 1'b0; opVal = 1'b0; opFn = 1'b0; opSelRem = 1'b0;
    opA = '0; opB = '0; opTag = '0;
    reqRdy = 1'b0; respVal = 1'b0; respMsg = '0; wbRdy = 1'b0;
    @(negedge clk);
    test_reset();
    test_unsigned_quot();
    test_signed_rem();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    test_divzero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
